mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter sharing the single physical-memory port between the instruction-cache and data-cache miss paths. It sits between the two caches (behind `imem_*`/`dmem_*` of the CPU datapath) and physical memory. It grants one cache-line transaction at a time, alternates fairly under contention, and registers all memory-side request outputs. Each grant holds until physical memory responds.

## Interface
- `LINE_WIDTH`, 256, cache-line width in bits
- `ADDR_WIDTH`, 32, byte address width
- `clk`  in  1  system clock; all state updates on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `i_read` / `i_write`  in  1 / 1  I-side line read / write request; held until `i_resp`
- `i_address`  in  ADDR_WIDTH  I-side line address
- `i_wdata`  in  LINE_WIDTH  I-side write line
- `i_resp`  out  1  I-side completion pulse
- `i_rdata`  out  LINE_WIDTH  I-side read line
- `d_read`, `d_write`, `d_address`, `d_wdata`, `d_resp`, `d_rdata`: same as I-side, for the D-cache
- `pmem_read` / `pmem_write`  out  1 / 1  memory request strobes (registered)
- `pmem_address`  out  ADDR_WIDTH  latched request address (registered)
- `pmem_wdata`  out  LINE_WIDTH  latched write line (registered)
- `pmem_resp`  in  1  memory completion, single-cycle pulse
- `pmem_rdata`  in  LINE_WIDTH  memory read line, valid with `pmem_resp`

## Operation
- States: IDLE, SERVE_I, SERVE_D, RECOVER.
- A requester is "pending" when its read or write is high. Read and write high together is treated as a write.
- IDLE, one side pending: grant that side.
- IDLE, both pending: grant D if `prefer_d`=1, else grant I.
- On every grant, `prefer_d` is set to (granted side == I). Result: strict alternation under continuous contention; neither side starves.
- Grant edge actions:
  - Latch the granted side's address, wdata and op into the `pmem_*` registers.
  - Assert exactly one of `pmem_read`/`pmem_write`.
  - Move to SERVE_x.
- SERVE_x:
  - `pmem_*` outputs are held constant.
  - Requester inputs are ignored after the latch.
  - When `pmem_resp`=1: `x_resp`=1 that cycle (combinational, gated by state). Next edge clears `pmem_read`/`pmem_write` and moves to RECOVER.
- RECOVER: one dead cycle, no grant, so the served cache can drop its request. Then IDLE.
- `i_rdata` and `d_rdata` are both wired to `pmem_rdata`. They are meaningful only while the matching `x_resp` is high.
- `pmem_resp` in IDLE or RECOVER is ignored: no `x_resp`, no state change.
- The non-granted side is never sent `x_resp`. Its request stays pending and is considered in the next IDLE.
- Requests arriving during SERVE/RECOVER are not queued. They are sampled only in IDLE.

## Timing
- Reset (`rst_n`=0, any time, asynchronous) forces:
  - state=IDLE, `prefer_d`=1;
  - `pmem_read`=`pmem_write`=0, `pmem_address`=0, `pmem_wdata`=0;
  - `i_resp`=`d_resp`=0.
- Reset mid-transaction abandons the transaction. Physical memory must tolerate the strobe dropping.
- Request high in IDLE at cycle t → `pmem_read`/`pmem_write` high from cycle t+1.
- `pmem_resp` at cycle r → `x_resp` at cycle r, strobes low at r+1, state IDLE at r+2.
- Earliest next strobe is r+3. Back-to-back transactions therefore cost 3 cycles of overhead plus memory latency.
- A request held through RECOVER is granted in the IDLE cycle at r+2.
- `x_resp` is exactly one cycle wide per transaction.

## Structure
- Shared package (`rv32i_types` or a new `mem_types`) holds:
  - enum `arb_state_t` {IDLE, SERVE_I, SERVE_D, RECOVER};
  - `LINE_WIDTH` default constant.
- Single module. Arbitration pick logic is a small `always_comb`; no sub-module needed.
- Registers: state, `prefer_d`, `pmem_address`, `pmem_wdata`, `pmem_read`, `pmem_write`.

## Test plan
- **Single I read:**
  - Stimulus: `i_read`=1, `i_address`=0x0000_0060; memory responds 4 cycles after the strobe with `pmem_rdata`=0xA5…A5.
  - Required: `pmem_read` rises at t+1 with `pmem_address`=0x60; `i_resp` pulses one cycle with `i_rdata`=0xA5…A5; `d_resp` never asserts.
- **Simultaneous requests after reset:**
  - Stimulus: `i_read` and `d_write` to 0x100 both high.
  - Required: D served first (`pmem_write`=1, `pmem_address`=0x100), then I; I strobe rises exactly 3 cycles after the D `pmem_resp`.
- **Continuous contention:**
  - Stimulus: both sides re-request immediately for 6 transactions.
  - Required: grant order D, I, D, I, D, I.
- **Input change after latch:**
  - Stimulus: `d_address` changes from 0x200 to 0x300 during SERVE_D.
  - Required: `pmem_address` stays 0x200 until completion.
- **Spurious memory response:**
  - Stimulus: `pmem_resp` pulse while IDLE.
  - Required: no `x_resp`; state remains IDLE.
- **Reset mid-transaction:**
  - Stimulus: `rst_n` low during SERVE_I.
  - Required: all outputs 0 asynchronously; after release, a pending `d_read` is granted first.

Source files
------------

// File: rtl/mem_types.sv
`default_nettype none
// ============================================================================
// mem_types : shared widths and arbiter state encoding for the memory path
// Revision  : 1.0
// ============================================================================
package mem_types;

  localparam int DEFAULT_LINE_WIDTH = 256;
  localparam int DEFAULT_ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RECOVER = 2'd3
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : shares one physical-memory port between I- and D-cache misses
// Revision    : 1.0
// ============================================================================
module mem_arbiter
  import mem_types::*;
#(
  parameter int LINE_WIDTH = DEFAULT_LINE_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_read,
  input  logic                  i_write,
  input  logic [ADDR_WIDTH-1:0] i_address,
  input  logic [LINE_WIDTH-1:0] i_wdata,
  output logic                  i_resp,
  output logic [LINE_WIDTH-1:0] i_rdata,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic                  d_resp,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic                  pmem_resp,
  input  logic [LINE_WIDTH-1:0] pmem_rdata
);

  arb_state_t r_state;
  logic       r_prefer_d;

  logic                  w_i_pend;
  logic                  w_d_pend;
  logic                  w_grant;
  logic                  w_pick_d;
  logic                  w_sel_write;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [LINE_WIDTH-1:0] w_sel_wdata;

  // Read+write together counts as a write, so the write strobe wins.
  always_comb begin
    w_i_pend    = i_read | i_write;
    w_d_pend    = d_read | d_write;
    w_grant     = w_i_pend | w_d_pend;
    w_pick_d    = w_d_pend & (~w_i_pend | r_prefer_d);
    w_sel_write = w_pick_d ? d_write   : i_write;
    w_sel_addr  = w_pick_d ? d_address : i_address;
    w_sel_wdata = w_pick_d ? d_wdata   : i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_prefer_d   <= 1'b1;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            pmem_address <= w_sel_addr;
            pmem_wdata   <= w_sel_wdata;
            pmem_write   <= w_sel_write;
            pmem_read    <= ~w_sel_write;
            r_prefer_d   <= ~w_pick_d;
            r_state      <= w_pick_d ? SERVE_D : SERVE_I;
          end
        end
        SERVE_I, SERVE_D: begin
          if (pmem_resp) begin
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            r_state    <= RECOVER;
          end
        end
        // Dead cycle lets the served cache drop its request before re-arbitration.
        RECOVER: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign i_resp  = (r_state == SERVE_I) & pmem_resp;
  assign d_resp  = (r_state == SERVE_D) & pmem_resp;
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter : scoreboard bench for mem_arbiter with a latency memory model
// Revision       : 1.0
// ============================================================================
module tb_mem_arbiter;

  localparam int LW = 256;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_read = 1'b0, i_write = 1'b0;
  logic [AW-1:0] i_address = '0;
  logic [LW-1:0] i_wdata = '0;
  logic          i_resp;
  logic [LW-1:0] i_rdata;
  logic          d_read = 1'b0, d_write = 1'b0;
  logic [AW-1:0] d_address = '0;
  logic [LW-1:0] d_wdata = '0;
  logic          d_resp;
  logic [LW-1:0] d_rdata;
  logic          pmem_read, pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic          pmem_resp = 1'b0;
  logic [LW-1:0] pmem_rdata = '0;

  mem_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_write(i_write), .i_address(i_address), .i_wdata(i_wdata),
    .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_resp(d_resp), .d_rdata(d_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          side;   // 0 = I, 1 = D
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    logic [LW-1:0] rdata;
  } txn_t;

  txn_t grant_q[$];
  txn_t resp_q[$];

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            mem_lat = 4;
  int            mem_cnt = 0;
  logic [31:0]   mem_pattern = 32'h1234_5678;
  logic          spurious = 1'b0;
  logic          auto_drop = 1'b1;
  logic          prev_strobe = 1'b0;
  logic          resp_prev = 1'b0;
  logic [AW-1:0] held_addr = '0;
  int            rise_cyc = 0, resp_cyc = 0, gap = 0;
  int            n_grant = 0, n_resp = 0, n_i_resp = 0, n_d_resp = 0;

  function automatic logic [LW-1:0] exp_line(input logic [AW-1:0] a);
    return {8{mem_pattern ^ a}};
  endfunction

  function automatic txn_t mk(input logic s, input logic w, input logic [AW-1:0] a,
                              input logic [LW-1:0] wd);
    txn_t t;
    t.side = s; t.wr = w; t.addr = a; t.wdata = wd; t.rdata = exp_line(a);
    return t;
  endfunction

  task automatic push(input txn_t t);
    grant_q.push_back(t);
    resp_q.push_back(t);
  endtask

  // One clock: memory model drives just after the edge, scoreboard samples at negedge.
  task automatic tick();
    txn_t t;
    logic strobe;
    @(posedge clk);
    cyc++;
    #1;
    if (spurious) begin
      pmem_resp  = 1'b1;
      pmem_rdata = {8{32'hDEAD_BEEF}};
      spurious   = 1'b0;
    end else if (pmem_read || pmem_write) begin
      if (mem_cnt == mem_lat) begin
        pmem_resp  = 1'b1;
        pmem_rdata = exp_line(pmem_address);
        mem_cnt    = 0;
      end else begin
        pmem_resp = 1'b0;
        mem_cnt++;
      end
    end else begin
      pmem_resp = 1'b0;
      mem_cnt   = 0;
    end
    @(negedge clk);
    strobe = pmem_read | pmem_write;
    if (resp_prev) begin
      checks++;
      if (strobe !== 1'b0) begin
        errors++;
        $display("FAIL strobe_clear cyc=%0d: strobe=%b required 0", cyc, strobe);
      end
    end
    if (strobe && !prev_strobe) begin
      checks++;
      n_grant++;
      rise_cyc = cyc;
      gap = cyc - resp_cyc;
      if (grant_q.size() == 0) begin
        errors++;
        $display("FAIL grant_unexpected cyc=%0d: addr=%h with no grant expected", cyc, pmem_address);
      end else begin
        t = grant_q.pop_front();
        held_addr = t.addr;
        if ({pmem_write, pmem_read, pmem_address, pmem_wdata} !== {t.wr, ~t.wr, t.addr, t.wdata}) begin
          errors++;
          $display("FAIL grant cyc=%0d: wr=%b rd=%b addr=%h required wr=%b rd=%b addr=%h (or wdata)",
                   cyc, pmem_write, pmem_read, pmem_address, t.wr, ~t.wr, t.addr);
        end
      end
    end else if (strobe) begin
      checks++;
      if (pmem_address !== held_addr) begin
        errors++;
        $display("FAIL addr_hold cyc=%0d: addr=%h required %h", cyc, pmem_address, held_addr);
      end
    end
    if (i_resp || d_resp) begin
      checks++;
      n_resp++;
      resp_cyc = cyc;
      if (i_resp) n_i_resp++;
      if (d_resp) n_d_resp++;
      if (resp_q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected cyc=%0d: i_resp=%b d_resp=%b", cyc, i_resp, d_resp);
      end else begin
        t = resp_q.pop_front();
        if ({i_resp, d_resp} !== (t.side ? 2'b01 : 2'b10) ||
            (t.side ? d_rdata : i_rdata) !== t.rdata) begin
          errors++;
          $display("FAIL resp cyc=%0d: i_resp=%b d_resp=%b required side=%0d (or rdata %h vs %h)",
                   cyc, i_resp, d_resp, t.side, (t.side ? d_rdata[31:0] : i_rdata[31:0]), t.rdata[31:0]);
        end
      end
      if (auto_drop) begin
        if (d_resp) begin d_read = 1'b0; d_write = 1'b0; end
        else        begin i_read = 1'b0; i_write = 1'b0; end
      end
    end
    resp_prev   = i_resp | d_resp;
    prev_strobe = strobe;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    pmem_resp = 1'b0;
    i_read = 1'b0; i_write = 1'b0; d_read = 1'b0; d_write = 1'b0;
    grant_q.delete(); resp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    prev_strobe = 1'b0; resp_prev = 1'b0; mem_cnt = 0; mem_lat = 4;
    auto_drop = 1'b1; spurious = 1'b0;
    n_grant = 0; n_resp = 0; n_i_resp = 0; n_d_resp = 0;
  endtask

  task automatic run_until_resp(input int n, input string name);
    for (int k = 0; k < 300 && n_resp < n; k++) tick();
    checks++;
    if (n_resp < n) begin
      errors++;
      $display("FAIL %s_timeout: responses=%0d required %0d", name, n_resp, n);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({pmem_read, pmem_write, pmem_address, pmem_wdata, i_resp, d_resp} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rd=%b wr=%b addr=%h i_resp=%b d_resp=%b required all 0",
               pmem_read, pmem_write, pmem_address, i_resp, d_resp);
    end
    apply_reset();
  endtask

  task automatic test_single_i();
    int req_cyc;
    apply_reset();
    mem_pattern = 32'hA5A5_A5A5 ^ 32'h0000_0060;
    i_wdata = {8{32'h1111_1111}};
    i_address = 32'h0000_0060;
    i_read = 1'b1;
    push('{side: 1'b0, wr: 1'b0, addr: 32'h60, wdata: {8{32'h1111_1111}}, rdata: {32{8'hA5}}});
    req_cyc = cyc;
    run_until_resp(1, "single_i");
    repeat (4) tick();
    checks++;
    if (rise_cyc !== req_cyc + 1) begin
      errors++;
      $display("FAIL single_i_latency: strobe cycle=%0d required %0d", rise_cyc, req_cyc + 1);
    end
    checks++;
    if (resp_cyc - rise_cyc !== 4) begin
      errors++;
      $display("FAIL single_i_resp_delay: %0d required 4", resp_cyc - rise_cyc);
    end
    checks++;
    if (n_i_resp !== 1 || n_d_resp !== 0) begin
      errors++;
      $display("FAIL single_i_resp_count: i=%0d d=%0d required i=1 d=0", n_i_resp, n_d_resp);
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    mem_pattern = 32'h1234_5678;
    d_address = 32'h100; d_wdata = {8{32'hCAFE_0100}}; d_write = 1'b1;
    i_address = 32'h140; i_wdata = '0; i_read = 1'b1;
    push(mk(1'b1, 1'b1, 32'h100, {8{32'hCAFE_0100}}));
    push(mk(1'b0, 1'b0, 32'h140, '0));
    run_until_resp(2, "simultaneous");
    checks++;
    if (gap !== 3) begin
      errors++;
      $display("FAIL simultaneous_gap: I strobe %0d cycles after D resp, required 3", gap);
    end
  endtask

  task automatic test_contention();
    apply_reset();
    auto_drop = 1'b0;
    d_address = 32'h400; d_wdata = {8{32'h0000_D00D}}; d_write = 1'b1;
    i_address = 32'h500; i_wdata = {8{32'h0000_1111}}; i_read = 1'b1;
    for (int k = 0; k < 3; k++) begin
      push(mk(1'b1, 1'b1, 32'h400, {8{32'h0000_D00D}}));
      push(mk(1'b0, 1'b0, 32'h500, {8{32'h0000_1111}}));
    end
    run_until_resp(6, "contention");
    d_write = 1'b0; i_read = 1'b0;
    repeat (4) tick();
    checks++;
    if (n_d_resp !== 3 || n_i_resp !== 3 || grant_q.size() !== 0) begin
      errors++;
      $display("FAIL contention_counts: d=%0d i=%0d left=%0d required 3 3 0",
               n_d_resp, n_i_resp, grant_q.size());
    end
  endtask

  task automatic test_latch();
    apply_reset();
    mem_lat = 6;
    d_address = 32'h200; d_wdata = '0; d_read = 1'b1;
    push(mk(1'b1, 1'b0, 32'h200, '0));
    for (int k = 0; k < 20 && n_grant < 1; k++) tick();
    d_address = 32'h300;
    repeat (3) tick();
    checks++;
    if (pmem_address !== 32'h200) begin
      errors++;
      $display("FAIL latch_addr: pmem_address=%h required 00000200", pmem_address);
    end
    run_until_resp(1, "latch");
    repeat (3) tick();
  endtask

  task automatic test_spurious();
    int req_cyc;
    apply_reset();
    tick();
    spurious = 1'b1;
    tick();
    checks++;
    if (i_resp !== 1'b0 || d_resp !== 1'b0) begin
      errors++;
      $display("FAIL spurious_resp: i_resp=%b d_resp=%b required 0 0", i_resp, d_resp);
    end
    i_address = 32'h80; i_wdata = '0; i_read = 1'b1;
    push(mk(1'b0, 1'b0, 32'h80, '0));
    req_cyc = cyc;
    tick();
    checks++;
    if (n_grant !== 1 || rise_cyc !== req_cyc + 1) begin
      errors++;
      $display("FAIL spurious_idle: grants=%0d strobe cycle=%0d required 1 at %0d",
               n_grant, rise_cyc, req_cyc + 1);
    end
    run_until_resp(1, "spurious");
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    i_address = 32'h600; i_wdata = {8{32'h6666_6666}}; i_read = 1'b1;
    push(mk(1'b0, 1'b0, 32'h600, {8{32'h6666_6666}}));
    for (int k = 0; k < 20 && n_grant < 1; k++) tick();
    repeat (2) tick();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    pmem_resp = 1'b0;
    d_address = 32'h700; d_wdata = '0; d_read = 1'b1;
    #1;
    checks++;
    if ({pmem_read, pmem_write, pmem_address, pmem_wdata, i_resp, d_resp} !== '0) begin
      errors++;
      $display("FAIL reset_async: rd=%b wr=%b addr=%h i_resp=%b d_resp=%b required all 0",
               pmem_read, pmem_write, pmem_address, i_resp, d_resp);
    end
    grant_q.delete(); resp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    prev_strobe = 1'b0; resp_prev = 1'b0; mem_cnt = 0;
    n_grant = 0; n_resp = 0; n_i_resp = 0; n_d_resp = 0;
    push(mk(1'b1, 1'b0, 32'h700, '0));
    push(mk(1'b0, 1'b0, 32'h600, {8{32'h6666_6666}}));
    run_until_resp(2, "reset_mid");
    repeat (3) tick();
  endtask

  initial begin
    test_reset();
    test_single_i();
    test_simultaneous();
    test_contention();
    test_latch();
    test_spurious();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
